// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic analyzer sample buffer: owns the write pointer,
// trigger bookkeeping and the oldest-first readout address stream.
module capture_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int HOLDOFF_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_arm,
  input  logic                     i_trigger,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_rd_start,
  input  logic                     i_raddr_ready,
  output logic                     o_we,
  output logic [ADDR_WIDTH-1:0]    o_waddr,
  output logic                     o_primed,
  output logic                     o_triggered,
  output logic                     o_stopped,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
  output logic [ADDR_WIDTH-1:0]    o_raddr,
  output logic                     o_raddr_valid,
  output logic                     o_raddr_last,
  output logic                     o_rd_done,
  output logic [2:0]               o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    PRIMED  = 3'd2,
    HOLDOFF = 3'd3,
    STOPPED = 3'd4,
    READOUT = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE = HOLDOFF_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]    raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]    trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0]    fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
  logic                     rd_done_q, rd_done_d;
  logic                     writing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      trig_addr_q <= '0;
      fill_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      holdoff_q   <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      trig_addr_q <= trig_addr_d;
      fill_cnt_q  <= fill_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      holdoff_q   <= holdoff_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign writing = (state_q == FILL) || (state_q == PRIMED) || (state_q == HOLDOFF);

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    trig_addr_d = trig_addr_q;
    fill_cnt_d  = fill_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    holdoff_d   = holdoff_q;
    rd_done_d   = 1'b0;

    if (writing) begin
      waddr_d = waddr_q + ADDR_ONE;
    end

    // Arm restarts capture from any state except an in-progress readout.
    if (i_arm && (state_q != READOUT)) begin
      state_d    = FILL;
      waddr_d    = '0;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          fill_cnt_d = fill_cnt_q + ADDR_ONE;
          if (fill_cnt_q == ADDR_MAX) begin
            state_d = PRIMED;
          end
        end
        PRIMED: begin
          if (i_trigger) begin
            trig_addr_d = waddr_q;
            if (i_holdoff == '0) begin
              state_d = STOPPED;
            end else begin
              holdoff_d = i_holdoff;
              state_d   = HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          holdoff_d = holdoff_q - HOLD_ONE;
          if (holdoff_q == HOLD_ONE) begin
            state_d = STOPPED;
          end
        end
        STOPPED: begin
          if (i_rd_start) begin
            raddr_d  = waddr_q;
            rd_cnt_d = '0;
            state_d  = READOUT;
          end
        end
        READOUT: begin
          if (i_raddr_ready) begin
            raddr_d  = raddr_q + ADDR_ONE;
            rd_cnt_d = rd_cnt_q + ADDR_ONE;
            if (rd_cnt_q == ADDR_MAX) begin
              state_d   = IDLE;
              rd_done_d = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs decode registered state only, so none depends on an input this cycle.
  assign o_we          = writing;
  assign o_waddr       = waddr_q;
  assign o_primed      = (state_q == PRIMED);
  assign o_triggered   = (state_q == HOLDOFF) || (state_q == STOPPED) || (state_q == READOUT);
  assign o_stopped     = (state_q == STOPPED) || (state_q == READOUT);
  assign o_trig_addr   = trig_addr_q;
  assign o_raddr       = raddr_q;
  assign o_raddr_valid = (state_q == READOUT);
  assign o_raddr_last  = (state_q == READOUT) && (rd_cnt_q == ADDR_MAX);
  assign o_rd_done     = rd_done_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_capture_ctrl;
  localparam int AW    = 4;
  localparam int HW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk           = 1'b0;
  logic          reset         = 1'b1;
  logic          i_arm         = 1'b0;
  logic          i_trigger     = 1'b0;
  logic [HW-1:0] i_holdoff     = '0;
  logic          i_rd_start    = 1'b0;
  logic          i_raddr_ready = 1'b0;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic          o_primed;
  logic          o_triggered;
  logic          o_stopped;
  logic [AW-1:0] o_trig_addr;
  logic [AW-1:0] o_raddr;
  logic          o_raddr_valid;
  logic          o_raddr_last;
  logic          o_rd_done;
  logic [2:0]    o_state;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase code, write pointer, remaining work counts and a
  // queue holding the readout addresses still owed to the host.
  int mState    = 0;
  int mWaddr    = 0;
  int mTrig     = 0;
  int mFillLeft = 0;
  int mHoldLeft = 0;
  bit mRdDone   = 1'b0;
  int readQ[$];

  always #5 clk = ~clk;

  capture_ctrl #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
    .clk(clk),
    .reset(reset),
    .i_arm(i_arm),
    .i_trigger(i_trigger),
    .i_holdoff(i_holdoff),
    .i_rd_start(i_rd_start),
    .i_raddr_ready(i_raddr_ready),
    .o_we(o_we),
    .o_waddr(o_waddr),
    .o_primed(o_primed),
    .o_triggered(o_triggered),
    .o_stopped(o_stopped),
    .o_trig_addr(o_trig_addr),
    .o_raddr(o_raddr),
    .o_raddr_valid(o_raddr_valid),
    .o_raddr_last(o_raddr_last),
    .o_rd_done(o_rd_done),
    .o_state(o_state)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic arm, input logic trig, input logic [HW-1:0] hold,
                               input logic rdStart, input logic ready);
    i_arm         = arm;
    i_trigger     = trig;
    i_holdoff     = hold;
    i_rd_start    = rdStart;
    i_raddr_ready = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Model advances on the same edge as the DUT, from the rules rather than any encoding.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState    = 0;
      mWaddr    = 0;
      mTrig     = 0;
      mFillLeft = 0;
      mHoldLeft = 0;
      mRdDone   = 1'b0;
      readQ.delete();
    end else begin
      mRdDone = 1'b0;
      if (i_arm && mState != 5) begin
        mState    = 1;
        mWaddr    = 0;
        mFillLeft = DEPTH;
      end else begin
        case (mState)
          1: begin
            mWaddr    = (mWaddr + 1) % DEPTH;
            mFillLeft = mFillLeft - 1;
            if (mFillLeft == 0) mState = 2;
          end
          2: begin
            if (i_trigger) begin
              mTrig = mWaddr;
              if (i_holdoff == 0) begin
                mState = 4;
              end else begin
                mHoldLeft = int'(i_holdoff);
                mState    = 3;
              end
            end
            mWaddr = (mWaddr + 1) % DEPTH;
          end
          3: begin
            mWaddr    = (mWaddr + 1) % DEPTH;
            mHoldLeft = mHoldLeft - 1;
            if (mHoldLeft == 0) mState = 4;
          end
          4: begin
            if (i_rd_start) begin
              for (int i = 0; i < DEPTH; i++) readQ.push_back((mWaddr + i) % DEPTH);
              mState = 5;
            end
          end
          5: begin
            if (i_raddr_ready) begin
              void'(readQ.pop_front());
              if (readQ.size() == 0) begin
                mState  = 0;
                mRdDone = 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("state", o_state, mState);
      checkOutput("we", o_we, (mState >= 1 && mState <= 3));
      checkOutput("waddr", o_waddr, mWaddr);
      checkOutput("primed", o_primed, (mState == 2));
      checkOutput("triggered", o_triggered, (mState >= 3));
      checkOutput("stopped", o_stopped, (mState >= 4));
      checkOutput("trig_addr", o_trig_addr, mTrig);
      checkOutput("raddr_valid", o_raddr_valid, (mState == 5));
      checkOutput("raddr_last", o_raddr_last, (mState == 5 && readQ.size() == 1));
      checkOutput("rd_done", o_rd_done, mRdDone);
      if (mState == 5 && readQ.size() > 0) checkOutput("raddr", o_raddr, readQ[0]);
    end
  end

  task automatic readoutToggle(input int startAddr);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("ro_addr", o_raddr, (startAddr + i) % DEPTH);
      checkOutput("ro_last", o_raddr_last, (i == DEPTH - 1));
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (i != DEPTH - 1) begin
        applyStimulus((i == 3), 1'b0, '0, 1'b0, 1'b0);
        checkOutput("ro_hold_addr", o_raddr, (startAddr + i + 1) % DEPTH);
      end
    end
    checkOutput("ro_done", o_rd_done, 1);
    checkOutput("ro_idle", o_state, 0);
  endtask

  task automatic asyncResetCheck(input string tag);
    #2;
    reset = 1'b1;
    #1;
    checkOutput({tag, "_state"}, o_state, 0);
    checkOutput({tag, "_we"}, o_we, 0);
    checkOutput({tag, "_waddr"}, o_waddr, 0);
    checkOutput({tag, "_trig_addr"}, o_trig_addr, 0);
    checkOutput({tag, "_raddr"}, o_raddr, 0);
    checkOutput({tag, "_valid"}, o_raddr_valid, 0);
    checkOutput({tag, "_flags"}, {o_primed, o_triggered, o_stopped, o_raddr_last, o_rd_done}, 0);
    i_arm         = 1'b0;
    i_trigger     = 1'b0;
    i_rd_start    = 1'b0;
    i_raddr_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", o_state, 0);
    checkOutput("rst_we", o_we, 0);
    checkOutput("rst_waddr", o_waddr, 0);
    reset = 1'b0;

    idleCycles(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("arm_state", o_state, 1);
    checkOutput("arm_waddr", o_waddr, 0);
    checkOutput("arm_we", o_we, 1);
    idleCycles(15);
    checkOutput("fill_end_waddr", o_waddr, 15);
    idleCycles(1);
    checkOutput("primed_flag", o_primed, 1);
    checkOutput("primed_waddr", o_waddr, 0);
    idleCycles(5);
    checkOutput("pre_trig_waddr", o_waddr, 5);
    applyStimulus(1'b0, 1'b1, HW'(3), 1'b0, 1'b0);
    checkOutput("hold_state", o_state, 3);
    checkOutput("hold_trig_addr", o_trig_addr, 5);
    checkOutput("hold_waddr0", o_waddr, 6);
    idleCycles(2);
    checkOutput("hold_waddr2", o_waddr, 8);
    idleCycles(1);
    checkOutput("stop_state", o_state, 4);
    checkOutput("stop_waddr", o_waddr, 9);
    checkOutput("stop_we", o_we, 0);
    checkOutput("stop_flags", {o_triggered, o_stopped}, 3);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("ro_state", o_state, 5);
    readoutToggle(9);
    idleCycles(1);
    checkOutput("ro_done_pulse_end", o_rd_done, 0);

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(31);
    checkOutput("h0_pre_waddr", o_waddr, 15);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checkOutput("h0_state", o_state, 4);
    checkOutput("h0_trig_addr", o_trig_addr, 15);
    checkOutput("h0_waddr", o_waddr, 0);
    checkOutput("h0_we", o_we, 0);

    applyStimulus(1'b1, 1'b1, HW'(20), 1'b0, 1'b0);
    repeat (16) applyStimulus(1'b0, 1'b1, HW'(20), 1'b0, 1'b0);
    checkOutput("tf_state", o_state, 2);
    checkOutput("tf_waddr", o_waddr, 0);
    applyStimulus(1'b0, 1'b1, HW'(20), 1'b0, 1'b0);
    checkOutput("tf_hold_state", o_state, 3);
    checkOutput("tf_trig_addr", o_trig_addr, 0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("rearm_state", o_state, 1);
    checkOutput("rearm_waddr", o_waddr, 0);

    idleCycles(16);
    applyStimulus(1'b0, 1'b1, HW'(10), 1'b0, 1'b0);
    idleCycles(2);
    asyncResetCheck("rst_hold");

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idleCycles(16);
    applyStimulus(1'b0, 1'b1, HW'(2), 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    asyncResetCheck("rst_read");

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                    HW'($urandom_range(0, 40)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 1));
    end
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
